// File: rtl/w_shreg_pkg.sv
// Shared definitions for the w_shreg_univ universal shift register:
// mode codes, burst FSM state encoding, shift-direction codes and a
// parity helper used when SHREG_PARITY_EN is defined.
package w_shreg_pkg;

    // Mode select codes (S input), applied while the burst engine is idle
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Burst FSM state encoding
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Shift direction codes; right moves data toward the last bit (QA -> QH)
    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

    // XOR-reduction of up to 32 bits; narrower vectors are zero-extended
    function automatic logic xor_reduce32(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/w_shreg_burst_ctl.sv
// Burst controller for w_shreg_univ. Owns the IDLE/RUN FSM, the remaining
// shift down-counter, BUSY/DONE and the direction register that drives SO.
// It tells the datapath when to shift (shift_en_o, direction dir_o) and when
// a START is being accepted so the mode operation is suppressed that cycle.
module w_shreg_burst_ctl
    import w_shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic          clk_i,
    input  logic          mr_i,
    input  logic          start_i,
    input  logic          dir_i,
    input  logic [CW-1:0] cnt_i,
    input  logic [2:0]    mode_i,
    output logic          shift_en_o,
    output logic          start_take_o,
    output logic          dir_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state logic: burst start/termination, count-down and direction tracking
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start_i) begin
                    if (cnt_i != CNT_ZERO) begin
                        state_d = ST_RUN;
                        cnt_d   = cnt_i;
                        dir_d   = dir_i;
                        busy_d  = 1'b1;
                    end else begin
                        // Zero-length burst: nothing to shift, just acknowledge
                        done_d = 1'b1;
                    end
                end else begin
                    case (mode_i)
                        MODE_SHR, MODE_ROR, MODE_ASR: dir_d = DIR_R;
                        MODE_SHL, MODE_ROL:           dir_d = DIR_L;
                        default:                      dir_d = dir_q;
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_ONE) begin
                    // Final shift happens on this edge
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q - CNT_ONE;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts a burst without DONE
    always_ff @(posedge clk_i) begin
        if (mr_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            dir_q   <= DIR_R;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign shift_en_o   = (state_q == ST_RUN);
    assign start_take_o = (state_q == ST_IDLE) && start_i;
    assign dir_o        = dir_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: rtl/w_shreg_univ.sv
// w_shreg_univ: WIDTH-bit universal shift register with eight modes
// (hold, shift, load, rotate, arithmetic shift, clear) and an autonomous
// burst engine. OUT[0] is QA; "right" moves data from QA toward QH.
// Optional macro SHREG_PARITY_EN adds a registered PARITY output that
// always equals the XOR of the current OUT.
module w_shreg_univ
    import w_shreg_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             MR,
    input  logic [2:0]       S,
    input  logic             DSR,
    input  logic             DSL,
    input  logic [0:WIDTH-1] IN,
    input  logic             START,
    input  logic             DIR,
    input  logic [CW-1:0]    CNT,
    output logic [0:WIDTH-1] OUT,
    output logic             SO,
    output logic             BUSY,
`ifdef SHREG_PARITY_EN
    output logic             PARITY,
`endif
    output logic             DONE
);

    logic [0:WIDTH-1] out_q, out_d;
    logic             shift_en_s;
    logic             start_take_s;
    logic             dir_s;

    w_shreg_burst_ctl #(
        .WIDTH (WIDTH)
    ) u_burst_ctl (
        .clk_i        (CLK),
        .mr_i         (MR),
        .start_i      (START),
        .dir_i        (DIR),
        .cnt_i        (CNT),
        .mode_i       (S),
        .shift_en_o   (shift_en_s),
        .start_take_o (start_take_s),
        .dir_o        (dir_s),
        .busy_o       (BUSY),
        .done_o       (DONE)
    );

    // Datapath next value: burst shift beats the S mode; a START cycle holds
    always_comb begin
        out_d = out_q;
        if (shift_en_s) begin
            if (dir_s == DIR_R) begin
                out_d = {DSR, out_q[0:WIDTH-2]};
            end else begin
                out_d = {out_q[1:WIDTH-1], DSL};
            end
        end else if (start_take_s) begin
            out_d = out_q;
        end else begin
            case (S)
                MODE_HOLD: out_d = out_q;
                MODE_SHR:  out_d = {DSR, out_q[0:WIDTH-2]};
                MODE_SHL:  out_d = {out_q[1:WIDTH-1], DSL};
                MODE_LOAD: out_d = IN;
                MODE_ROR:  out_d = {out_q[WIDTH-1], out_q[0:WIDTH-2]};
                MODE_ROL:  out_d = {out_q[1:WIDTH-1], out_q[0]};
                MODE_ASR:  out_d = {out_q[0], out_q[0:WIDTH-2]};
                MODE_CLR:  out_d = {WIDTH{1'b0}};
                default:   out_d = out_q;
            endcase
        end
    end

    // Register contents with synchronous reset
    always_ff @(posedge CLK) begin
        if (MR) begin
            out_q <= {WIDTH{1'b0}};
        end else begin
            out_q <= out_d;
        end
    end

`ifdef SHREG_PARITY_EN
    logic parity_q;

    // Parity is computed from the next value so it lines up with OUT
    always_ff @(posedge CLK) begin
        if (MR) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= xor_reduce32(32'(out_d));
        end
    end

    assign PARITY = parity_q;
`endif

    assign OUT = out_q;
    // Serial out taps the end the data is moving toward
    assign SO  = (dir_s == DIR_L) ? out_q[0] : out_q[WIDTH-1];

endmodule
